a_axi_write_bcast_sequencer: RTL and testbench

//  Sequences one AXI-Lite control write (AW+W) from the host into NUM_SLR per-SLR control ports.

---
 rtl/a_axi_write_bcast_sequencer_pkg.sv | 8 +
 rtl/a_axi_bcast_slr_tracker.sv | 42 ++++
 rtl/a_axi_write_bcast_sequencer.sv | 99 +++++++++
 tb/tb_a_axi_write_bcast_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/a_axi_write_bcast_sequencer_pkg.sv
// a_axi_write_bcast_sequencer_pkg: FSM states, AXI response codes and response merge helper
package a_axi_write_bcast_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} resp_t;
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/a_axi_bcast_slr_tracker.sv
// a_axi_bcast_slr_tracker: per-SLR AW/W/B pending bits and downstream handshakes for one write
module a_axi_bcast_slr_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       awready,
  input  logic       wready,
  input  logic       bvalid,
  input  logic [1:0] bresp,
  output logic       awvalid,
  output logic       wvalid,
  output logic       bready,
  output logic       done,
  output logic       pending,
  output logic [1:0] resp
);
  logic aw_pend, w_pend, b_pend, b_fire;
  always_comb begin
    awvalid = aw_pend;
    wvalid = w_pend;
    bready = b_pend & ~aw_pend & ~w_pend;
    b_fire = bready & bvalid;
    resp = b_fire ? bresp : 2'd0;
    // done looks ahead to the pend bits after this cycle's handshakes
    done = ~(aw_pend & ~awready) & ~(w_pend & ~wready) & ~(b_pend & ~b_fire);
    pending = aw_pend | w_pend | b_pend;
  end
  always_ff @(posedge clk)
    if (rst) begin
      aw_pend <= 1'b0;
      w_pend <= 1'b0;
      b_pend <= 1'b0;
    end else if (start) begin
      aw_pend <= 1'b1;
      w_pend <= 1'b1;
      b_pend <= 1'b1;
    end else begin
      aw_pend <= aw_pend & ~awready;
      w_pend <= w_pend & ~wready;
      b_pend <= b_pend & ~b_fire;
    end
endmodule

// File: rtl/a_axi_write_bcast_sequencer.sv
// a_axi_write_bcast_sequencer: broadcasts one host AXI-Lite write to NUM_SLR ports and merges their B responses
module a_axi_write_bcast_sequencer
  import a_axi_write_bcast_sequencer_pkg::*;
#(
  parameter int C_S_AXI_CONTROL_ADDR_WIDTH = 9,
  parameter int C_S_AXI_CONTROL_DATA_WIDTH = 32,
  parameter int C_S_AXI_CONTROL_WSTRB_WIDTH = 4,
  parameter int NUM_SLR = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                   ap_clk,
  input  logic                                   ap_rst,
  input  logic                                   s_axi_control_AWVALID,
  output logic                                   s_axi_control_AWREADY,
  input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]  s_axi_control_AWADDR,
  input  logic                                   s_axi_control_WVALID,
  output logic                                   s_axi_control_WREADY,
  input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]  s_axi_control_WDATA,
  input  logic [C_S_AXI_CONTROL_WSTRB_WIDTH-1:0] s_axi_control_WSTRB,
  output logic                                   s_axi_control_BVALID,
  input  logic                                   s_axi_control_BREADY,
  output logic [1:0]                             s_axi_control_BRESP,
  output logic [NUM_SLR-1:0]                     m_axi_control_AWVALID,
  input  logic [NUM_SLR-1:0]                     m_axi_control_AWREADY,
  output logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]  m_axi_control_AWADDR,
  output logic [NUM_SLR-1:0]                     m_axi_control_WVALID,
  input  logic [NUM_SLR-1:0]                     m_axi_control_WREADY,
  output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]  m_axi_control_WDATA,
  output logic [C_S_AXI_CONTROL_WSTRB_WIDTH-1:0] m_axi_control_WSTRB,
  input  logic [NUM_SLR-1:0]                     m_axi_control_BVALID,
  output logic [NUM_SLR-1:0]                     m_axi_control_BREADY,
  input  logic [2*NUM_SLR-1:0]                   m_axi_control_BRESP,
  output logic                                   stall_flag,
  output logic [NUM_SLR-1:0]                     stall_mask
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_next;
  logic accept;
  logic [NUM_SLR-1:0] done, pending;
  logic [2*NUM_SLR-1:0] resp;
  logic [1:0] resp_acc, resp_merge;
  logic [TW-1:0] timer;
  for (genvar g = 0; g < NUM_SLR; g++) begin : g_slr
    a_axi_bcast_slr_tracker u_trk (
      .clk(ap_clk),
      .rst(ap_rst),
      .start(accept),
      .awready(m_axi_control_AWREADY[g]),
      .wready(m_axi_control_WREADY[g]),
      .bvalid(m_axi_control_BVALID[g]),
      .bresp(m_axi_control_BRESP[2*g+:2]),
      .awvalid(m_axi_control_AWVALID[g]),
      .wvalid(m_axi_control_WVALID[g]),
      .bready(m_axi_control_BREADY[g]),
      .done(done[g]),
      .pending(pending[g]),
      .resp(resp[2*g+:2])
    );
  end
  always_comb begin
    accept = (state == IDLE) & s_axi_control_AWVALID & s_axi_control_WVALID & ~ap_rst;
    s_axi_control_AWREADY = accept;
    s_axi_control_WREADY = accept;
    s_axi_control_BVALID = state == RESP;
    s_axi_control_BRESP = resp_acc;
    resp_merge = resp_acc;
    for (int i = 0; i < NUM_SLR; i++) resp_merge = resp_max(resp_merge, resp[2*i+:2]);
    state_next = accept ? ISSUE :
                 (state == ISSUE && &done) ? RESP :
                 (state == RESP && s_axi_control_BREADY) ? IDLE : state;
  end
  always_ff @(posedge ap_clk)
    if (ap_rst) begin
      state <= IDLE;
      resp_acc <= OKAY;
      timer <= '0;
      stall_flag <= 1'b0;
      stall_mask <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        resp_acc <= OKAY;
        timer <= '0;
      end else if (state == ISSUE) begin
        resp_acc <= resp_merge;
        if (timer != TW'(TIMEOUT_CYCLES)) timer <= timer + 1'b1;
        if (timer == TW'(TIMEOUT_CYCLES - 1) && !stall_flag) begin
          stall_flag <= 1'b1;
          stall_mask <= pending;
        end
      end
    end
  always_ff @(posedge ap_clk)
    if (accept) begin
      m_axi_control_AWADDR <= s_axi_control_AWADDR;
      m_axi_control_WDATA <= s_axi_control_WDATA;
      m_axi_control_WSTRB <= s_axi_control_WSTRB;
    end
endmodule

// File: tb/tb_a_axi_write_bcast_sequencer.sv
// tb_a_axi_write_bcast_sequencer: directed scoreboard bench for the AXI-Lite write broadcast sequencer
module tb_a_axi_write_bcast_sequencer;
  localparam int N = 2;
  logic ap_clk = 1'b0, ap_rst;
  logic s_axi_control_AWVALID, s_axi_control_AWREADY, s_axi_control_WVALID, s_axi_control_WREADY;
  logic s_axi_control_BVALID, s_axi_control_BREADY;
  logic [8:0] s_axi_control_AWADDR, m_axi_control_AWADDR;
  logic [31:0] s_axi_control_WDATA, m_axi_control_WDATA;
  logic [3:0] s_axi_control_WSTRB, m_axi_control_WSTRB;
  logic [1:0] s_axi_control_BRESP;
  logic [N-1:0] m_axi_control_AWVALID, m_axi_control_AWREADY, m_axi_control_WVALID, m_axi_control_WREADY;
  logic [N-1:0] m_axi_control_BVALID, m_axi_control_BREADY, stall_mask;
  logic [2*N-1:0] m_axi_control_BRESP;
  logic stall_flag;
  int checks = 0, errors = 0;
  int b_cnt = 0, b_snap = 0;
  int aw_cnt[N], w_cnt[N], aw_snap[N], w_snap[N];
  logic [1:0] exp_q[$];

  always #5 ap_clk = ~ap_clk;

  a_axi_write_bcast_sequencer #(.NUM_SLR(N), .TIMEOUT_CYCLES(8)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_axi_control_AWVALID(s_axi_control_AWVALID), .s_axi_control_AWREADY(s_axi_control_AWREADY),
    .s_axi_control_AWADDR(s_axi_control_AWADDR),
    .s_axi_control_WVALID(s_axi_control_WVALID), .s_axi_control_WREADY(s_axi_control_WREADY),
    .s_axi_control_WDATA(s_axi_control_WDATA), .s_axi_control_WSTRB(s_axi_control_WSTRB),
    .s_axi_control_BVALID(s_axi_control_BVALID), .s_axi_control_BREADY(s_axi_control_BREADY),
    .s_axi_control_BRESP(s_axi_control_BRESP),
    .m_axi_control_AWVALID(m_axi_control_AWVALID), .m_axi_control_AWREADY(m_axi_control_AWREADY),
    .m_axi_control_AWADDR(m_axi_control_AWADDR),
    .m_axi_control_WVALID(m_axi_control_WVALID), .m_axi_control_WREADY(m_axi_control_WREADY),
    .m_axi_control_WDATA(m_axi_control_WDATA), .m_axi_control_WSTRB(m_axi_control_WSTRB),
    .m_axi_control_BVALID(m_axi_control_BVALID), .m_axi_control_BREADY(m_axi_control_BREADY),
    .m_axi_control_BRESP(m_axi_control_BRESP),
    .stall_flag(stall_flag), .stall_mask(stall_mask)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial for (int i = 0; i < N; i++) begin aw_cnt[i] = 0; w_cnt[i] = 0; end

  // monitor: downstream beat counters and host B scoreboard
  always @(posedge ap_clk) begin
    for (int i = 0; i < N; i++) begin
      if (m_axi_control_AWVALID[i] && m_axi_control_AWREADY[i]) aw_cnt[i] <= aw_cnt[i] + 1;
      if (m_axi_control_WVALID[i] && m_axi_control_WREADY[i]) w_cnt[i] <= w_cnt[i] + 1;
    end
    if (!ap_rst && s_axi_control_BVALID && s_axi_control_BREADY) begin
      b_cnt <= b_cnt + 1;
      if (exp_q.size() == 0) check("unexpected_host_b", 1, 0);
      else check("host_bresp", int'(s_axi_control_BRESP), int'(exp_q.pop_front()));
    end
  end

  task automatic slaves(input logic [1:0] awr, input logic [1:0] wr, input logic [1:0] bv, input logic [3:0] br);
    m_axi_control_AWREADY = awr;
    m_axi_control_WREADY = wr;
    m_axi_control_BVALID = bv;
    m_axi_control_BRESP = br;
  endtask

  task automatic host_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] e, input bit push);
    bit acc = 0;
    b_snap = b_cnt;
    for (int i = 0; i < N; i++) begin aw_snap[i] = aw_cnt[i]; w_snap[i] = w_cnt[i]; end
    if (push) exp_q.push_back(e);
    @(posedge ap_clk); #1;
    s_axi_control_AWADDR = a;
    s_axi_control_WDATA = d;
    s_axi_control_WSTRB = s;
    s_axi_control_AWVALID = 1;
    s_axi_control_WVALID = 1;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge ap_clk);
      acc = s_axi_control_AWREADY && s_axi_control_WREADY;
    end
    check("host_accept", int'(acc), 1);
    @(posedge ap_clk); #1;
    s_axi_control_AWVALID = 0;
    s_axi_control_WVALID = 0;
  endtask

  task automatic wait_b();
    for (int n = 0; n < 50 && b_cnt == b_snap; n++) @(negedge ap_clk);
    check("host_b_count", b_cnt - b_snap, 1);
  endtask

  task automatic check_beats();
    for (int i = 0; i < N; i++) begin
      check($sformatf("aw_beats_slr%0d", i), aw_cnt[i] - aw_snap[i], 1);
      check($sformatf("w_beats_slr%0d", i), w_cnt[i] - w_snap[i], 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ap_rst = 1;
    s_axi_control_AWVALID = 0; s_axi_control_WVALID = 0; s_axi_control_BREADY = 1;
    s_axi_control_AWADDR = 0; s_axi_control_WDATA = 0; s_axi_control_WSTRB = 0;
    slaves(2'b00, 2'b00, 2'b00, 4'h0);
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_m_awvalid", int'(m_axi_control_AWVALID), 0);
    check("rst_m_wvalid", int'(m_axi_control_WVALID), 0);
    check("rst_m_bready", int'(m_axi_control_BREADY), 0);
    check("rst_s_bvalid", int'(s_axi_control_BVALID), 0);
    check("rst_s_bresp", int'(s_axi_control_BRESP), 0);
    check("rst_stall", int'({stall_flag, stall_mask}), 0);
    @(posedge ap_clk); #1 ap_rst = 0;

    // 1: zero-wait broadcast, latency 1/2/3
    slaves(2'b11, 2'b11, 2'b11, 4'h0);
    host_write(9'h1A4, 32'hDEADBEEF, 4'hA, 2'd0, 1);
    @(negedge ap_clk);
    check("t1_m_awvalid_c1", int'(m_axi_control_AWVALID), 3);
    check("t1_m_wvalid_c1", int'(m_axi_control_WVALID), 3);
    check("t1_m_bready_c1", int'(m_axi_control_BREADY), 0);
    check("t1_awaddr", int'(m_axi_control_AWADDR), 'h1A4);
    check("t1_wdata", int'(m_axi_control_WDATA == 32'hDEADBEEF), 1);
    check("t1_wstrb", int'(m_axi_control_WSTRB), 'hA);
    @(negedge ap_clk);
    check("t1_m_bready_c2", int'(m_axi_control_BREADY), 3);
    check("t1_s_bvalid_c2", int'(s_axi_control_BVALID), 0);
    @(negedge ap_clk);
    check("t1_s_bvalid_c3", int'(s_axi_control_BVALID), 1);
    wait_b();
    check_beats();

    // 2: SLR1 AWREADY low for 5 cycles
    slaves(2'b01, 2'b11, 2'b11, 4'h0);
    host_write(9'h010, 32'h12345678, 4'hF, 2'd0, 1);
    repeat (5) @(posedge ap_clk);
    #1 m_axi_control_AWREADY = 2'b11;
    @(negedge ap_clk);
    check("t2_m_awvalid_c6", int'(m_axi_control_AWVALID), 2);
    check("t2_m_wvalid_c6", int'(m_axi_control_WVALID), 0);
    wait_b();
    check_beats();
    check("t2_no_stall", int'(stall_flag), 0);

    // 3: OKAY + DECERR together, host BREADY held off
    s_axi_control_BREADY = 0;
    slaves(2'b11, 2'b11, 2'b11, 4'b1100);
    host_write(9'h020, 32'h0, 4'h1, 2'd3, 1);
    @(negedge ap_clk);
    @(negedge ap_clk);
    check("t3_m_bready_c2", int'(m_axi_control_BREADY), 3);
    @(negedge ap_clk);
    check("t3_m_bready_c3", int'(m_axi_control_BREADY), 0);
    check("t3_bvalid_c3", int'(s_axi_control_BVALID), 1);
    check("t3_bresp_c3", int'(s_axi_control_BRESP), 3);
    @(negedge ap_clk);
    check("t3_bvalid_hold", int'(s_axi_control_BVALID), 1);
    check("t3_bresp_hold", int'(s_axi_control_BRESP), 3);
    @(posedge ap_clk); #1 s_axi_control_BREADY = 1;
    wait_b();

    // 3b: SLVERR + EXOKAY merges to SLVERR
    slaves(2'b11, 2'b11, 2'b11, 4'b0110);
    host_write(9'h024, 32'h55AA55AA, 4'hF, 2'd2, 1);
    wait_b();

    // 4: AWVALID alone must not be accepted
    slaves(2'b11, 2'b11, 2'b11, 4'h0);
    exp_q.push_back(2'd0);
    b_snap = b_cnt;
    @(posedge ap_clk); #1;
    s_axi_control_AWADDR = 9'h030; s_axi_control_WDATA = 32'hCAFEF00D; s_axi_control_WSTRB = 4'h3;
    s_axi_control_AWVALID = 1;
    for (int n = 0; n < 4; n++) begin
      @(negedge ap_clk);
      check("t4_awready_low", int'(s_axi_control_AWREADY), 0);
      check("t4_wready_low", int'(s_axi_control_WREADY), 0);
      @(posedge ap_clk); #1;
    end
    s_axi_control_WVALID = 1;
    @(negedge ap_clk);
    check("t4_awready_rise", int'(s_axi_control_AWREADY), 1);
    check("t4_wready_rise", int'(s_axi_control_WREADY), 1);
    @(posedge ap_clk); #1;
    s_axi_control_AWVALID = 0; s_axi_control_WVALID = 0;
    @(negedge ap_clk);
    check("t4_wdata", int'(m_axi_control_WDATA == 32'hCAFEF00D), 1);
    wait_b();

    // 5: SLR1 never answers B, stall sets after 8 ISSUE cycles
    slaves(2'b11, 2'b11, 2'b01, 4'h0);
    host_write(9'h040, 32'h1, 4'hF, 2'd0, 0);
    repeat (8) @(negedge ap_clk);
    check("t5_stall_c8", int'(stall_flag), 0);
    @(negedge ap_clk);
    check("t5_stall_c9", int'(stall_flag), 1);
    check("t5_stall_mask", int'(stall_mask), 2);
    check("t5_no_bvalid", int'(s_axi_control_BVALID), 0);
    check("t5_bready_slr1", int'(m_axi_control_BREADY), 2);

    // 6: reset during ISSUE with SLR1 AW pending, then a clean write
    @(posedge ap_clk); #1 ap_rst = 1;
    @(posedge ap_clk); #1 ap_rst = 0;
    slaves(2'b01, 2'b11, 2'b11, 4'h0);
    host_write(9'h050, 32'h2, 4'hF, 2'd0, 0);
    @(posedge ap_clk); #1 ap_rst = 1;
    @(negedge ap_clk);
    check("t6_awpend_before_rst", int'(m_axi_control_AWVALID), 2);
    @(posedge ap_clk); #1 ap_rst = 0;
    @(negedge ap_clk);
    check("t6_m_awvalid", int'(m_axi_control_AWVALID), 0);
    check("t6_m_wvalid", int'(m_axi_control_WVALID), 0);
    check("t6_m_bready", int'(m_axi_control_BREADY), 0);
    check("t6_s_bvalid", int'(s_axi_control_BVALID), 0);
    check("t6_stall", int'({stall_flag, stall_mask}), 0);
    slaves(2'b11, 2'b11, 2'b11, 4'h0);
    host_write(9'h060, 32'h3, 4'hF, 2'd0, 1);
    wait_b();
    check_beats();

    repeat (3) @(negedge ap_clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
